// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pipe_pkg : shared pipeline-boundary payload types          | rev 1.0
// ============================================================================
package riscv_pipe_pkg;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  wr_reg;
  } mem_wb_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

  localparam int MEM_WB_W      = $bits(mem_wb_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  function automatic logic [1:0] count_live(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// pipe_slot : one valid + payload + ctrl entry with load/clear enables | rev 1.0
// ============================================================================
module pipe_slot
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W = MEM_WB_W,
  parameter int CTRL_W = MEM_WB_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic              valid_d;
  logic              load_en_d;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear beats load; only the valid bit is killable, payload moves on load only.
  always_comb begin
    valid_d   = valid_q;
    load_en_d = 1'b0;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d   = 1'b1;
      load_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_en_d) begin
        data_q <= data_i;
        ctrl_q <= ctrl_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// pipe_stage_hs : valid/ready pipeline register with flush and optional skid | rev 1.0
// ============================================================================
module pipe_stage_hs
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W = MEM_WB_W,
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_acc;
  logic              w_drn;
  logic              w_main_valid;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_main_din;
  logic [CTRL_W-1:0] w_main_cin;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;

  assign w_acc = in_valid & in_ready & ~flush;
  assign w_drn = w_main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              w_main_free;
      logic              w_skid_load;
      logic              w_skid_clr;
      logic [DATA_W-1:0] w_skid_data;
      logic [CTRL_W-1:0] w_skid_ctrl;

      assign in_ready    = ~w_skid_valid;
      assign w_main_free = ~w_main_valid | w_drn;

      // Skid is always older than the input, so it refills main first.
      assign w_main_load = ~flush & w_main_free & (w_skid_valid | w_acc);
      assign w_main_clr  = flush | (w_main_free & ~w_skid_valid & ~w_acc);
      assign w_main_din  = w_skid_valid ? w_skid_data : in_data;
      assign w_main_cin  = w_skid_valid ? w_skid_ctrl : in_ctrl;

      assign w_skid_load = ~flush & ~w_main_free & w_acc;
      assign w_skid_clr  = flush | (w_main_free & w_skid_valid);

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_skid_load),
        .clr_i   (w_skid_clr),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (w_skid_valid),
        .data_o  (w_skid_data),
        .ctrl_o  (w_skid_ctrl)
      );
    end else begin : g_no_skid
      assign in_ready     = ~w_main_valid | out_ready;
      assign w_skid_valid = 1'b0;
      assign w_main_load  = w_acc;
      assign w_main_clr   = flush | (w_drn & ~w_acc);
      assign w_main_din   = in_data;
      assign w_main_cin   = in_ctrl;
    end
  endgenerate

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_main_load),
    .clr_i   (w_main_clr),
    .data_i  (w_main_din),
    .ctrl_i  (w_main_cin),
    .valid_o (w_main_valid),
    .data_o  (w_main_data),
    .ctrl_o  (w_main_ctrl)
  );

  // Control bits must never leak out of a bubble.
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign occupancy = count_live(w_main_valid, w_skid_valid);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_hs : directed bench for pipe_stage_hs (SKID=1 and SKID=0) | rev 1.0
// ============================================================================
module tb_pipe_stage_hs;

  localparam int DW  = 69;
  localparam int CW  = 2;
  localparam int DW0 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  logic           flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [DW0-1:0] in_data0, out_data0;
  logic [CW-1:0]  in_ctrl0, out_ctrl0;
  logic [1:0]     occupancy0;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_hs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_hs #(.DATA_W(DW0), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0)
  );

  task automatic idle_all();
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0; in_ctrl = '0;
    flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0; in_ctrl0 = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_ctrl !== 2'b00) begin n_bad++; $display("FAIL reset_out_ctrl: got %b want 00", out_ctrl); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_skid0: got %b want 1", in_ready0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_skid0: got %b want 0", out_valid0); end
    rst = 0;
  endtask

  // Four words, no back-pressure: one-cycle latency, full throughput.
  task automatic test_stream();
    out_ready = 1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(32'h10 + c)) begin
          n_bad++; $display("FAIL stream_data c%0d: got v=%b %0h want v=1 %0h", c, out_valid, out_data, 32'h10 + c);
        end
        n_cmp++; if (out_ctrl !== 2'b01) begin n_bad++; $display("FAIL stream_ctrl c%0d: got %b want 01", c, out_ctrl); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle c%0d: got v=%b want 0", c, out_valid); end
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
      if (c < 4) begin
        in_valid = 1; in_data = DW'(32'h11 + c); in_ctrl = 2'b01;
      end else begin
        in_valid = 0;
      end
    end
  endtask

  // Stall with a third word offered: it must wait upstream and order must hold.
  task automatic test_stall();
    logic [DW-1:0] src [3];
    logic [DW-1:0] got [$];
    int si = 0;
    src[0] = DW'(32'hA0); src[1] = DW'(32'hA1); src[2] = DW'(32'hA2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = (c == 0 || c >= 4);
      in_valid  = (si < 3);
      in_data   = (si < 3) ? src[si] : '0;
      in_ctrl   = 2'b10;
      #1;
      if (c == 2 || c == 3) begin
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL stall_occ c%0d: got %0d want 2", c, occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
        n_cmp++; if (out_data !== src[0]) begin n_bad++; $display("FAIL stall_hold c%0d: got %0h want a0", c, out_data); end
      end
      if (c == 4) begin
        n_cmp++; if (si !== 2) begin n_bad++; $display("FAIL stall_upstream_hold: accepted %0d want 2", si); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) si++;
    end
    in_valid = 0; out_ready = 0;
    n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL stall_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== src[i]) begin n_bad++; $display("FAIL stall_order[%0d]: got %0h want %0h", i, got[i], src[i]); end
      end
    end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL stall_final_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_data = DW'(32'hB0); in_ctrl = 2'b11;
    @(negedge clk);
    in_data = DW'(32'hB1);
    @(negedge clk);
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    n_cmp++; if (out_ctrl !== 2'b11) begin n_bad++; $display("FAIL flush_pre_ctrl: got %b want 11", out_ctrl); end
    flush = 1; in_valid = 1; in_data = DW'(32'hFF); in_ctrl = 2'b11;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 2'b00) begin n_bad++; $display("FAIL flush_out_ctrl: got %b want 00", out_ctrl); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== DW'(32'hB0)) begin n_bad++; $display("FAIL flush_payload_kept: got %0h want b0", out_data); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_ff c%0d: got v=%b data=%0h want v=0", c, out_valid, out_data); end
    end
    out_ready = 0;
  endtask

  task automatic test_rst_stall();
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_data = DW'(32'hC0); in_ctrl = 2'b01;
    @(negedge clk);
    in_data = DW'(32'hC1);
    @(negedge clk);
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL rst_pre_occ: got %0d want 2", occupancy); end
    rst = 1; flush = 1; in_valid = 1; in_data = DW'(32'hC2);
    @(negedge clk);
    rst = 0; flush = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_ctrl !== 2'b00) begin n_bad++; $display("FAIL rst_out_ctrl: got %b want 00", out_ctrl); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_c2_dropped: got v=%b want 0", out_valid); end
  endtask

  // Single-entry variant under toggling back-pressure.
  task automatic test_skid0();
    logic [DW0-1:0] got [$];
    int si = 0;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      @(negedge clk);
      out_ready0 = (c % 2 == 0);
      in_valid0  = (si < 8);
      in_data0   = DW0'(32'h30 + si);
      #1;
      n_cmp++; if (in_ready0 !== (!out_valid0 || out_ready0)) begin
        n_bad++; $display("FAIL skid0_in_ready c%0d: got %b want %b", c, in_ready0, (!out_valid0 || out_ready0));
      end
      n_cmp++; if (occupancy0 > 2'd1) begin n_bad++; $display("FAIL skid0_occ c%0d: got %0d want <=1", c, occupancy0); end
      if (out_valid0 && out_ready0) got.push_back(out_data0);
      if (in_valid0 && in_ready0) si++;
    end
    in_valid0 = 0; out_ready0 = 0;
    n_cmp++; if (got.size() !== 8) begin n_bad++; $display("FAIL skid0_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== DW0'(32'h30 + i)) begin n_bad++; $display("FAIL skid0_order[%0d]: got %0h want %0h", i, got[i], 32'h30 + i); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_rst_stall();
    test_skid0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
